// File: rtl/tt_slot_scheduler.sv
// Time-triggered slot scheduler: cyclic time base, offset table, pending/overrun tracking, one-grant-at-a-time handshake.
// Optional macro SCHED_RR_EN selects round-robin arbitration instead of fixed lowest-index priority.
module tt_slot_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = 2,
    parameter int GTB_W     = 32,
    parameter int CYCLE_LEN = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [GTB_W-1:0]     cfg_offset,
    input  logic                 cfg_en,
    input  logic                 ovr_clr,
    output logic                 tx_valid,
    output logic [IDX_W-1:0]     tx_slot,
    input  logic                 tx_ready,
    output logic [GTB_W-1:0]     gtb,
    output logic                 cycle_start,
    output logic [NUM_SLOTS-1:0] overrun
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [GTB_W-1:0] GTB_LAST = GTB_W'(CYCLE_LEN - 1);

    state_t               state;
    logic [GTB_W-1:0]     offset_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] en_q;
    logic [NUM_SLOTS-1:0] pending_q;
    logic [NUM_SLOTS-1:0] due;
    logic [NUM_SLOTS-1:0] acc;
    logic                 accept;
    logic [IDX_W-1:0]     win;
    logic                 win_found;
`ifdef SCHED_RR_EN
    logic [IDX_W-1:0]     rr_ptr;
`endif

    // gtb never exceeds CYCLE_LEN-1, so offsets at or beyond CYCLE_LEN cannot match.
    always_comb begin
        due = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            due[i] = run && en_q[i] && (gtb == offset_q[i]);
        end
    end

    assign accept = (state == GRANT) && tx_valid && tx_ready;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            acc[i] = accept && (tx_slot == IDX_W'(i));
        end
    end

`ifdef SCHED_RR_EN
    // Search begins one past the last accepted slot, wrapping around the table.
    always_comb begin
        int cand;
        win       = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            cand = (int'(rr_ptr) + 1 + k) % NUM_SLOTS;
            if (!win_found && pending_q[cand]) begin
                win       = IDX_W'(cand);
                win_found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win       = '0;
        win_found = |pending_q;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                win = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            gtb         <= '0;
            cycle_start <= 1'b0;
            tx_valid    <= 1'b0;
            tx_slot     <= '0;
            overrun     <= '0;
            pending_q   <= '0;
            en_q        <= '0;
            state       <= IDLE;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                offset_q[i] <= '0;
            end
`ifdef SCHED_RR_EN
            rr_ptr      <= IDX_W'(NUM_SLOTS - 1);
`endif
        end else begin
            if (run && (gtb == GTB_LAST)) begin
                gtb         <= '0;
                cycle_start <= 1'b1;
            end else begin
                if (run) begin
                    gtb <= gtb + GTB_W'(1);
                end
                cycle_start <= 1'b0;
            end

            // Out-of-range indices match no entry and are dropped.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    offset_q[i] <= cfg_offset;
                    en_q[i]     <= cfg_en;
                end
            end

            // A new event on a slot being accepted re-arms it instead of counting as overrun.
            pending_q <= due | (pending_q & ~acc);
            overrun   <= (overrun & ~{NUM_SLOTS{ovr_clr}}) | (due & pending_q & ~acc);

            case (state)
                IDLE: begin
                    if (win_found) begin
                        tx_valid <= 1'b1;
                        tx_slot  <= win;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
`ifdef SCHED_RR_EN
                        rr_ptr   <= tx_slot;
`endif
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
